// File: rtl/datain_pkt_arb.sv
// Packet-level round-robin arbiter: shares one registered router input byte stream
// between NUM_SRC packet sources, policing inter-packet gap, start timeout and length.
module datain_pkt_arb #(
    parameter int NUM_SRC   = 4,
    parameter int BW        = 8,
    parameter int GAP_CYC   = 1,
    parameter int MAX_LEN   = 64,
    parameter int START_TMO = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [NUM_SRC*BW-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_gnt,
    output logic                  packet_valid,
    output logic [BW-1:0]         data_in,
    output logic                  len_err,
    output logic                  tmo_err,
    output logic                  proto_err,
    output logic                  busy,
    output logic [15:0]           pkt_cnt
);
    localparam int IW = $clog2(NUM_SRC);
    localparam logic [7:0] LEN_MAX  = 8'(MAX_LEN);
    localparam logic [7:0] TMO_LAST = 8'(START_TMO - 1);
    localparam logic [7:0] GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_XFER, S_DRAIN, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic               pv_q, pv_d;
    logic [BW-1:0]      data_q, data_d;
    logic               len_err_q, len_err_d;
    logic               tmo_err_q, tmo_err_d;
    logic               proto_err_q, proto_err_d;
    logic [7:0]         bcnt_q, bcnt_d;
    logic [7:0]         tmr_q, tmr_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;
    logic               sel_vld;
    logic [BW-1:0]      sel_data;
    logic [NUM_SRC-1:0] own;
    state_t             end_state;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_SRC - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [IW-1:0] v);
        logic [NUM_SRC-1:0] m;
        m    = '0;
        m[v] = 1'b1;
        return m;
    endfunction

    // First requester at or after the round-robin pointer, cyclically.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_q;
        cand     = rr_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!pick_vld && src_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (idx_q == IW'(k)) sel_data = src_data[k*BW +: BW];
        end
    end

    assign sel_vld   = src_valid[idx_q];
    // The owning source keeps its exemption while draining an over-long packet.
    assign own       = (state_q == S_GRANT || state_q == S_XFER || state_q == S_DRAIN)
                       ? onehot(idx_q) : '0;
    assign end_state = (GAP_CYC == 0) ? S_IDLE : S_GAP;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        pv_d        = 1'b0;
        data_d      = '0;
        len_err_d   = 1'b0;
        tmo_err_d   = 1'b0;
        proto_err_d = |(src_valid & ~own);
        bcnt_d      = bcnt_q;
        tmr_d       = tmr_q;
        pkt_cnt_d   = pkt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = onehot(pick_idx);
                    idx_d   = pick_idx;
                    tmr_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (sel_vld) begin
                    pv_d    = 1'b1;
                    data_d  = sel_data;
                    bcnt_d  = 8'd1;
                    state_d = S_XFER;
                end else if (!src_req[idx_q]) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (tmr_q >= TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    gnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_XFER: begin
                if (sel_vld) begin
                    if (bcnt_q == LEN_MAX) begin
                        len_err_d = 1'b1;
                        gnt_d     = '0;
                        rr_d      = wrap_inc(idx_q);
                        state_d   = S_DRAIN;
                    end else begin
                        pv_d   = 1'b1;
                        data_d = sel_data;
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end else begin
                    gnt_d     = '0;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    rr_d      = wrap_inc(idx_q);
                    tmr_d     = '0;
                    state_d   = end_state;
                end
            end
            S_DRAIN: begin
                if (!sel_vld) begin
                    tmr_d   = '0;
                    state_d = end_state;
                end
            end
            S_GAP: begin
                if (tmr_q >= GAP_LAST) state_d = S_IDLE;
                else                   tmr_d   = tmr_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            idx_q       <= '0;
            rr_q        <= '0;
            pv_q        <= 1'b0;
            data_q      <= '0;
            len_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
            bcnt_q      <= '0;
            tmr_q       <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            pv_q        <= pv_d;
            data_q      <= data_d;
            len_err_q   <= len_err_d;
            tmo_err_q   <= tmo_err_d;
            proto_err_q <= proto_err_d;
            bcnt_q      <= bcnt_d;
            tmr_q       <= tmr_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign src_gnt      = gnt_q;
    assign packet_valid = pv_q;
    assign data_in      = data_q;
    assign len_err      = len_err_q;
    assign tmo_err      = tmo_err_q;
    assign proto_err    = proto_err_q;
    assign busy         = (state_q != S_IDLE);
    assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_datain_pkt_arb.sv
// Randomized scoreboard bench for datain_pkt_arb: source agents feed packets, a
// round-robin reference predicts grant order and stream bytes, a monitor checks.
module tb_datain_pkt_arb;
    localparam int N    = 4;
    localparam int GAP  = 2;
    localparam int MAXL = 64;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  src_req = '0;
    logic [N-1:0]  src_valid = '0;
    logic [N*8-1:0] src_data = '0;
    logic [N-1:0]  src_gnt;
    logic          packet_valid;
    logic [7:0]    data_in;
    logic          len_err, tmo_err, proto_err, busy;
    logic [15:0]   pkt_cnt;

    datain_pkt_arb #(.NUM_SRC(N), .BW(8), .GAP_CYC(GAP), .MAX_LEN(MAXL), .START_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_valid(src_valid),
        .src_data(src_data), .src_gnt(src_gnt), .packet_valid(packet_valid),
        .data_in(data_in), .len_err(len_err), .tmo_err(tmo_err),
        .proto_err(proto_err), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    // agent modes: 0 idle, 1 requesting, 2 sending, 3 requesting but never starts
    int mode [N];
    int plen [N];
    int sent [N];
    int rogue[N];
    logic [7:0] pbytes[N][128];
    logic [7:0] exp_q[$];
    int grant_log[$];
    int model_rr = 0, exp_pkt = 0, exp_len = 0, exp_tmo = 0, exp_proto = 0;
    int obs_len = 0, obs_tmo = 0, obs_proto = 0;
    int tmo_gcyc = 0, tmo_owner = -1, last_run = 0;
    logic [N-1:0] gnt_prev = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[(model_rr + i) % N]) return (model_rr + i) % N;
        return -1;
    endfunction

    function automatic int gidx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin mode[k] = 0; rogue[k] = 0; sent[k] = 0; end
        exp_q.delete();
        model_rr = 0; exp_pkt = 0; gnt_prev = '0; tmo_owner = -1;
    endtask

    task automatic load(input int k, input int len, input bit silent);
        plen[k] = len; sent[k] = 0;
        for (int i = 0; i < len; i++) pbytes[k][i] = 8'($urandom);
        mode[k] = silent ? 3 : 1;
    endtask

    // Called once per cycle at the falling edge: reacts to grants and drives all sources.
    task automatic drive();
        logic [N-1:0] r, v;
        logic [N*8-1:0] d;
        bit any_rogue;
        if (src_gnt != '0 && gnt_prev == '0) begin
            int k;
            k = gidx(src_gnt);
            chk("grant_rr_order", k, pick(src_req));
            grant_log.push_back(k);
            if (k >= 0 && mode[k] == 1) begin
                mode[k] = 2; sent[k] = 0;
                for (int i = 0; i < plen[k] && i < MAXL; i++) exp_q.push_back(pbytes[k][i]);
                if (plen[k] > MAXL) exp_len++; else exp_pkt++;
            end else if (k >= 0 && mode[k] == 3) begin
                tmo_gcyc = cyc; tmo_owner = k; exp_tmo++;
            end else begin
                chk("grant_to_requester", (k >= 0) ? mode[k] : -1, 1);
            end
        end
        gnt_prev = src_gnt;
        r = '0; v = '0; d = '0; any_rogue = 0;
        for (int k = 0; k < N; k++) begin
            case (mode[k])
                0: if (rogue[k] > 0) begin
                       rogue[k]--; v[k] = 1'b1; d[k*8 +: 8] = 8'hEE; any_rogue = 1;
                   end
                1: r[k] = 1'b1;
                2: if (sent[k] < plen[k]) begin
                       r[k] = 1'b1; v[k] = 1'b1; d[k*8 +: 8] = pbytes[k][sent[k]]; sent[k]++;
                   end else begin
                       mode[k] = 0; model_rr = (k + 1) % N;
                   end
                3: if (tmo_err && k == tmo_owner) mode[k] = 0; else r[k] = 1'b1;
                default: mode[k] = 0;
            endcase
        end
        if (any_rogue) exp_proto++;
        src_req = r; src_valid = v; src_data = d;
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < N; k++) if (mode[k] != 0 || rogue[k] != 0) return 0;
        return 1;
    endfunction

    task automatic wait_quiet(input int budget);
        int n = 0;
        while (n < budget && !(all_idle() && !busy && exp_q.size() == 0 && src_valid == '0)) begin
            tick(); n++;
        end
        chk("quiet_within_budget", (n < budget), 1);
        tick(); tick();
    endtask

    task automatic wait_mode(input int k, input int m, input int budget);
        int n = 0;
        while (mode[k] != m && n < budget) begin tick(); n++; end
        chk("wait_agent_mode", (n < budget), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        src_req = '0; src_valid = '0; src_data = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the stream carries a byte.
    initial begin : monitor
        int lowrun, hirun;
        bit had;
        lowrun = 0; hirun = 0; had = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin had = 0; lowrun = 0; hirun = 0; continue; end
            chk("gnt_onehot0", $onehot0(src_gnt), 1);
            if (packet_valid) begin
                if (hirun == 0 && had) chk("min_gap_ok", (lowrun >= GAP + 1), 1);
                hirun++; lowrun = 0;
                if (exp_q.size() == 0) chk("unexpected_byte", packet_valid, 0);
                else chk("data_in", data_in, exp_q.pop_front());
            end else begin
                chk("data_idle_zero", data_in, 0);
                if (hirun > 0) begin last_run = hirun; had = 1; end
                hirun = 0; lowrun++;
            end
            if (len_err) obs_len++;
            if (proto_err) obs_proto++;
            if (tmo_err) begin
                obs_tmo++;
                chk("tmo_latency", cyc - tmo_gcyc, TMO);
                chk("tmo_gnt_drop", src_gnt, 0);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int pc0, l0, t0, p0, r;
        logic [7:0] par;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {src_gnt, packet_valid, len_err, tmo_err, proto_err, busy}, 0);
        chk("reset_data", data_in, 0);
        chk("reset_pkt_cnt", pkt_cnt, 0);
        rst_n = 1'b1;

        // Single 5-byte packet from source 2.
        load(2, 5, 0);
        pbytes[2][0] = 8'h0D; pbytes[2][1] = 8'h11; pbytes[2][2] = 8'h22; pbytes[2][3] = 8'h33;
        par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        pbytes[2][4] = par;
        tick(); tick();
        chk("single_gnt", src_gnt, 4'b0100);
        chk("single_busy", busy, 1);
        wait_quiet(200);
        chk("single_pv_len", last_run, 5);
        chk("single_pkt_cnt", pkt_cnt, 1);

        // All four at once from a fresh pointer, then source 0 again.
        do_reset();
        grant_log.delete();
        for (int k = 0; k < N; k++) load(k, 4, 0);
        wait_quiet(400);
        chk("rr4_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr4_order", grant_log[i], i);
        chk("rr4_pkt_cnt", pkt_cnt, 4);
        load(0, 4, 0);
        wait_quiet(200);
        chk("rr4_again", grant_log[4], 0);

        // Over-long packet from source 1 with source 2 waiting.
        pc0 = pkt_cnt; l0 = obs_len; grant_log.delete();
        load(1, 70, 0); load(2, 5, 0);
        wait_quiet(400);
        chk("len_err_once", obs_len - l0, 1);
        chk("len_pkt_cnt", pkt_cnt, pc0 + 1);
        chk("len_next_src2", grant_log[1], 2);

        // Source 3 never starts; source 0 proceeds after the timeout.
        t0 = obs_tmo; pc0 = pkt_cnt;
        load(3, 4, 1); load(0, 6, 0);
        wait_quiet(400);
        chk("tmo_once", obs_tmo - t0, 1);
        chk("tmo_other_served", pkt_cnt, pc0 + 1);

        // Source 0 drives valid while source 1 owns the stream.
        p0 = obs_proto;
        load(1, 10, 0);
        wait_mode(1, 2, 50);
        tick();
        rogue[0] = 3;
        wait_quiet(200);
        chk("proto_pulses", obs_proto - p0, 3);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (mode[k] == 0 && rogue[k] == 0) begin
                    r = $urandom_range(0, 199);
                    if (r < 10)       load(k, $urandom_range(1, 72), 0);
                    else if (r == 10) load(k, 1, 1);
                    else if (r == 11) rogue[k] = 1;
                end
            end
            tick();
        end
        wait_quiet(3000);
        chk("rand_pkt_cnt", pkt_cnt, 16'(exp_pkt));
        chk("rand_len_err", obs_len, exp_len);
        chk("rand_tmo_err", obs_tmo, exp_tmo);
        chk("rand_proto_err", obs_proto, exp_proto);

        // Reset in the middle of a transfer after the pointer has moved on.
        load(1, 4, 0);
        wait_quiet(200);
        load(2, 20, 0);
        wait_mode(2, 2, 50);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_pv", packet_valid, 0);
        chk("rst_mid_gnt", src_gnt, 0);
        chk("rst_mid_busy", busy, 0);
        clear_model();
        src_req = '0; src_valid = '0; src_data = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        load(3, 3, 0); load(0, 3, 0);
        wait_quiet(200);
        chk("rst_prio_src0", grant_log[0], 0);
        chk("rst_pkt_cnt", pkt_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
